// File: rtl/dac_pwm_driver.sv
// PWM audio driver: double-buffered 8-bit duty latched at period boundaries,
// with a per-period gain ramp on enable/disable to suppress speaker pops.
module dac_pwm_driver #(
    parameter int PRESCALE  = 1,
    parameter int RAMP_STEP = 64
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       en_i,
    input  logic [7:0] sample_i,
    output logic       pwm_o,
    output logic       period_o,
    output logic       active_o
);

    typedef enum logic [1:0] {S_OFF, S_FADE_IN, S_RUN, S_FADE_OUT} state_t;

    localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);
    localparam logic [7:0] STEP   = 8'(RAMP_STEP);

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t     r_state;
    logic [7:0] r_pre;
    logic [7:0] r_phase;
    logic [7:0] r_ramp;
    logic [7:0] r_duty;
    logic       r_pwm;
    logic       r_period;
    logic       r_active;

    state_t     w_state_nxt;
    logic [7:0] w_ramp_nxt;
    logic [7:0] w_duty_nxt;
    logic       w_period_nxt;
    logic       w_clear;
    logic       w_tick;
    logic       w_wrap;
    logic [7:0] w_ramp_up;
    logic [7:0] w_ramp_dn;

    assign w_tick    = (r_pre == PS_MAX);
    assign w_wrap    = w_tick && (r_phase == 8'hFF);
    assign w_ramp_up = sat_add(r_ramp, STEP);
    assign w_ramp_dn = sat_sub(r_ramp, STEP);

    // Every active state follows the same wrap rule: en_i picks the ramp
    // direction, and the saturated ramp value decides RUN / OFF / fading.
    always_comb begin
        w_state_nxt  = r_state;
        w_ramp_nxt   = r_ramp;
        w_duty_nxt   = r_duty;
        w_period_nxt = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_OFF: begin
                w_clear = 1'b1;
                if (en_i) begin
                    w_state_nxt  = S_FADE_IN;
                    w_ramp_nxt   = STEP;
                    w_duty_nxt   = min8(STEP, sample_i);
                    w_period_nxt = 1'b1;
                end
            end
            default: begin
                if (w_wrap) begin
                    if (en_i) begin
                        w_ramp_nxt  = w_ramp_up;
                        w_state_nxt = (w_ramp_up == 8'hFF) ? S_RUN : S_FADE_IN;
                    end else begin
                        w_ramp_nxt  = w_ramp_dn;
                        w_state_nxt = (w_ramp_dn == 8'd0) ? S_OFF : S_FADE_OUT;
                    end
                    if (w_state_nxt == S_OFF) begin
                        w_duty_nxt = 8'd0;
                    end else begin
                        w_duty_nxt   = min8(w_ramp_nxt, sample_i);
                        w_period_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state  <= S_OFF;
            r_pre    <= 8'd0;
            r_phase  <= 8'd0;
            r_ramp   <= 8'd0;
            r_duty   <= 8'd0;
            r_pwm    <= 1'b0;
            r_period <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ramp   <= w_ramp_nxt;
            r_duty   <= w_duty_nxt;
            r_period <= w_period_nxt;
            r_active <= (w_state_nxt != S_OFF);
            r_pwm    <= (r_state != S_OFF) && (r_phase < r_duty);
            if (w_clear) begin
                r_pre   <= 8'd0;
                r_phase <= 8'd0;
            end else if (w_tick) begin
                r_pre   <= 8'd0;
                r_phase <= r_phase + 8'd1;
            end else begin
                r_pre   <= r_pre + 8'd1;
            end
        end
    end

    assign pwm_o    = r_pwm;
    assign period_o = r_period;
    assign active_o = r_active;

endmodule
